slc3_io_responder: RTL
======================

Name: slc3_io_responder

Overview:
- Memory-mapped I/O responder on the SLC-3 CPU memory bus; the target side of the CPU's load/store transactions to the I/O page.
- Reads at IO_SW_ADDR return the board switches.
- Writes at IO_HEX_ADDR drive HEX3..HEX0; writes at IO_LED_ADDR drive LED.
- Also conditions the raw Continue push-button into a one-cycle pulse for the CPU's pause/continue logic.

Parameters:
- IO_SW_ADDR, 16'hFFFF, read address of switches; write address of hex display register.
- IO_LED_ADDR, 16'hFFFE, write address of LED register.
- WAIT_CYCLES, 2, access latency in clocks from request detect to R assertion; legal range 1..15.
- DEBOUNCE_CYCLES, 16, consecutive stable samples required before a button level is accepted.

Ports:
- Clk  in  1  system clock, 50 MHz.
- Reset  in  1  synchronous, active-high reset.
- ADDR  in  16  CPU address (MAR).
- Data_from_CPU  in  16  CPU write data (MDR out).
- Data_to_CPU  out  16  read data to CPU.
- MEM_OE  in  1  active-low read strobe.
- MEM_WE  in  1  active-low write strobe.
- R  out  1  ready; one-cycle high pulse completing a transaction.
- SW  in  10  board switches, asynchronous.
- Continue  in  1  raw push-button, active-low, asynchronous.
- Cont_pulse  out  1  one-cycle pulse per debounced Continue press.
- LED  out  10  LED register.
- HEX0..HEX3  out  7 each  active-low seven-segment digits, HEX0 = nibble [3:0].

Behaviour:
- Reset (synchronous): state IDLE, R=0, Data_to_CPU=0, hex_reg=0 (HEX0..3 each 7'b1000000), LED=0, Cont_pulse=0, debounce counter 0, accepted button level = 1 (released).
- Reset asserted mid-transaction aborts it: no register update, no R pulse.
- Request definition: sel = (ADDR==IO_SW_ADDR) | (ADDR==IO_LED_ADDR); req = sel & (~MEM_OE | ~MEM_WE).
- FSM states:
  - IDLE: on req, latch op (write if MEM_WE==0, else read; both low → write wins), latch ADDR and Data_from_CPU, load counter = WAIT_CYCLES-1, go to ACCESS.
  - ACCESS: decrement counter; at 0 go to DONE.
  - DONE: R=1 for exactly this cycle.
    - Write to IO_SW_ADDR: hex_reg ← latched data.
    - Write to IO_LED_ADDR: LED ← latched data[9:0].
    - Read: Data_to_CPU ← {6'b0, SW_sync}.
    - Go to HOLD.
  - HOLD: wait until MEM_OE==1 and MEM_WE==1, then go to IDLE. No second R pulse while strobes stay low.
- Latency: R is high exactly WAIT_CYCLES+1 clocks after the first cycle req is sampled high.
- Data_to_CPU holds its value until the next read completes.
- Read of IO_LED_ADDR returns 16'h0000 (see Optional Feature).
- Strobes to unmapped addresses are ignored; the block stays in IDLE.
- SW passes through a 2-FF synchronizer; the read samples the synchronized value in DONE.
- Hex digits: combinational decode of hex_reg nibbles 0–F, standard active-low patterns (0=7'b1000000, 8=7'b0000000, F=7'b0001110).
- Continue conditioning:
  - 2-FF synchronizer feeds the debouncer.
  - Counter resets whenever the synchronized level differs from the accepted level.
  - When DEBOUNCE_CYCLES consecutive differing samples are seen, the accepted level flips.
  - Accepted level 1→0 (press) yields Cont_pulse=1 for exactly one cycle. Release yields no pulse.
  - Holding the button produces a single pulse.

Optional Feature:
- Macro IO_READBACK_EN.
- Defined: reads of IO_LED_ADDR return {6'b0, LED}; no read path to hex_reg exists, since IO_SW_ADDR reads always return switches.
- Undefined: reads of IO_LED_ADDR return 16'h0000. All other behaviour is identical.

Test Plan:
- Reset then idle → HEX0..3 = 7'b1000000, LED=0, R=0, Cont_pulse=0.
- SW=10'h2A5, ADDR=16'hFFFF, MEM_OE=0 held, WAIT_CYCLES=2 → R high exactly 3 clocks after request, Data_to_CPU=16'h02A5; one R pulse only until OE returns high.
- ADDR=16'hFFFF, Data_from_CPU=16'h8C3F, MEM_WE=0 → after R: HEX3=8 (7'b0000000), HEX2=C (7'b1000110), HEX1=3 (7'b0110000), HEX0=F (7'b0001110).
- ADDR=16'hFFFE, Data=16'hFFFF, MEM_WE=0 and MEM_OE=0 simultaneously → treated as write, LED=10'h3FF. Follow-up read of 16'hFFFE → 16'h03FF with IO_READBACK_EN defined, 16'h0000 without.
- Continue bounced low/high every 3 clocks for 40 clocks, then held low 40 clocks, then released → exactly one Cont_pulse, asserted DEBOUNCE_CYCLES+2..+3 clocks after the stable low begins; none on release.
- Write to 16'hFFFF with Reset asserted during ACCESS → no R pulse, hex_reg stays 0, FSM in IDLE; a fresh read afterwards completes normally.

Source files
------------

// File: rtl/slc3_io_responder.sv
// SLC-3 memory-mapped I/O responder: switch reads, hex/LED register writes,
// fixed-latency ready handshake and debounced Continue push-button pulse.
// Optional build macro IO_READBACK_EN: reads of IO_LED_ADDR return the LED
// register instead of zero.
module slc3_io_responder #(
    parameter logic [15:0] IO_SW_ADDR      = 16'hFFFF,
    parameter logic [15:0] IO_LED_ADDR     = 16'hFFFE,
    parameter int unsigned WAIT_CYCLES     = 2,
    parameter int unsigned DEBOUNCE_CYCLES = 16
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_from_CPU,
    output logic [15:0] Data_to_CPU,
    input  logic        MEM_OE,
    input  logic        MEM_WE,
    output logic        R,
    input  logic [9:0]  SW,
    input  logic        Continue,
    output logic        Cont_pulse,
    output logic [9:0]  LED,
    output logic [6:0]  HEX0,
    output logic [6:0]  HEX1,
    output logic [6:0]  HEX2,
    output logic [6:0]  HEX3
);

    localparam int unsigned WCW = 4;
    localparam int unsigned DCW = $clog2(DEBOUNCE_CYCLES + 1);

    typedef enum logic [1:0] {
        IDLE,
        ACCESS,
        DONE,
        HOLD
    } state_t;

    state_t          state_q;
    logic            write_q;
    logic [15:0]     addr_q;
    logic [15:0]     wdata_q;
    logic [WCW-1:0]  wcnt_q;
    logic            r_q;
    logic [15:0]     rdata_q;
    logic [15:0]     hex_q;
    logic [9:0]      led_q;

    logic [9:0]      sw_meta_q;
    logic [9:0]      sw_sync_q;

    logic            cont_meta_q;
    logic            cont_sync_q;
    logic            cont_level_q;
    logic [DCW-1:0]  db_cnt_q;
    logic            cont_pulse_q;

    logic            sel_c;
    logic            req_c;
    logic [15:0]     rd_value_c;

    // Address decode and request detect for the I/O page.
    always_comb begin
        sel_c = (ADDR == IO_SW_ADDR) | (ADDR == IO_LED_ADDR);
        req_c = sel_c & (~MEM_OE | ~MEM_WE);
    end

    // Read data selection for the latched address; switches unless the LED address.
    always_comb begin
        rd_value_c = {6'b0, sw_sync_q};
        if (addr_q == IO_LED_ADDR) begin
`ifdef IO_READBACK_EN
            rd_value_c = {6'b0, led_q};
`else
            rd_value_c = 16'h0000;
`endif
        end
    end

    // Switch synchronizer (two flops) ahead of the read path.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            sw_meta_q <= '0;
            sw_sync_q <= '0;
        end else begin
            sw_meta_q <= SW;
            sw_sync_q <= sw_meta_q;
        end
    end

    // Bus transaction FSM with registered ready, read data and output registers.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= IDLE;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wcnt_q  <= '0;
            r_q     <= 1'b0;
            rdata_q <= '0;
            hex_q   <= '0;
            led_q   <= '0;
        end else begin
            r_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (req_c) begin
                        // Write wins when both strobes are low.
                        write_q <= ~MEM_WE;
                        addr_q  <= ADDR;
                        wdata_q <= Data_from_CPU;
                        wcnt_q  <= WCW'(WAIT_CYCLES - 1);
                        state_q <= ACCESS;
                    end
                end
                ACCESS: begin
                    if (wcnt_q == '0) begin
                        state_q <= DONE;
                    end else begin
                        wcnt_q <= wcnt_q - WCW'(1);
                    end
                end
                DONE: begin
                    r_q <= 1'b1;
                    if (write_q) begin
                        if (addr_q == IO_SW_ADDR) begin
                            hex_q <= wdata_q;
                        end else if (addr_q == IO_LED_ADDR) begin
                            led_q <= wdata_q[9:0];
                        end
                    end else begin
                        rdata_q <= rd_value_c;
                    end
                    state_q <= HOLD;
                end
                HOLD: begin
                    // Wait for the CPU to drop both strobes before rearming.
                    if (MEM_OE && MEM_WE) begin
                        state_q <= IDLE;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    // Continue synchronizer, debouncer and press-edge pulse generator.
    always_ff @(posedge Clk) begin
        if (Reset) begin
            cont_meta_q  <= 1'b1;
            cont_sync_q  <= 1'b1;
            cont_level_q <= 1'b1;
            db_cnt_q     <= '0;
            cont_pulse_q <= 1'b0;
        end else begin
            cont_meta_q  <= Continue;
            cont_sync_q  <= cont_meta_q;
            cont_pulse_q <= 1'b0;
            if (cont_sync_q != cont_level_q) begin
                if (db_cnt_q == DCW'(DEBOUNCE_CYCLES - 1)) begin
                    cont_level_q <= cont_sync_q;
                    db_cnt_q     <= '0;
                    // Pulse only on the released-to-pressed transition.
                    cont_pulse_q <= cont_level_q;
                end else begin
                    db_cnt_q <= db_cnt_q + DCW'(1);
                end
            end else begin
                db_cnt_q <= '0;
            end
        end
    end

    // Active-low seven-segment decode of one nibble.
    function automatic logic [6:0] seg7(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'b1000000;
            4'h1: s = 7'b1111001;
            4'h2: s = 7'b0100100;
            4'h3: s = 7'b0110000;
            4'h4: s = 7'b0011001;
            4'h5: s = 7'b0010010;
            4'h6: s = 7'b0000010;
            4'h7: s = 7'b1111000;
            4'h8: s = 7'b0000000;
            4'h9: s = 7'b0010000;
            4'hA: s = 7'b0001000;
            4'hB: s = 7'b0000011;
            4'hC: s = 7'b1000110;
            4'hD: s = 7'b0100001;
            4'hE: s = 7'b0000110;
            default: s = 7'b0001110;
        endcase
        return s;
    endfunction

    assign HEX0        = seg7(hex_q[3:0]);
    assign HEX1        = seg7(hex_q[7:4]);
    assign HEX2        = seg7(hex_q[11:8]);
    assign HEX3        = seg7(hex_q[15:12]);
    assign Data_to_CPU = rdata_q;
    assign R           = r_q;
    assign LED         = led_q;
    assign Cont_pulse  = cont_pulse_q;

endmodule
